// File: rtl/fir_channel_arbiter.sv
// Shares one FIR engine between CH_COUNT requesters; 4 cycles overhead + engine latency; results held until res_ready.
// Optional FIR_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin. Watchdog aborts a stuck engine.
module fir_channel_arbiter #(
    parameter int CH_COUNT       = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int OUT_WIDTH      = 40,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CH_COUNT-1:0]            req,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] req_data,
    output logic [CH_COUNT-1:0]            gnt,
    output logic                           fir_input_valid,
    output logic [DATA_WIDTH-1:0]          fir_data_in,
    output logic [$clog2(CH_COUNT)-1:0]    fir_ch_sel,
    input  logic                           fir_output_valid,
    input  logic [OUT_WIDTH-1:0]           fir_data_out,
    output logic                           res_valid,
    output logic [$clog2(CH_COUNT)-1:0]    res_ch,
    output logic [OUT_WIDTH-1:0]           res_data,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int CW    = $clog2(CH_COUNT);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  cnt_at_lim;
    logic                  win_vld;
    logic [CW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] win_data;

`ifdef FIR_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = CW'(i);
            end
        end
    end
`else
    logic [CW-1:0] rr;
    logic [CW-1:0] scan_idx;

    // Descending offset scan: the channel closest to rr is written last and wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            scan_idx = CW'((int'(rr) + i) % CH_COUNT);
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end
`endif

    always_comb begin
        win_data = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            if (CW'(i) == win_idx) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cnt_at_lim = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A done pulse in the last allowed WAIT cycle takes priority over the abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (fir_output_valid) begin
                    state_nxt = RESULT;
                end else if (cnt_at_lim) begin
                    state_nxt = IDLE;
                end
            end
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt             <= '0;
            fir_input_valid <= 1'b0;
            fir_data_in     <= '0;
            fir_ch_sel      <= '0;
            res_valid       <= 1'b0;
            res_ch          <= '0;
            res_data        <= '0;
            timeout_err     <= 1'b0;
            cnt             <= '0;
`ifndef FIR_ARB_FIXED_PRIO_EN
            rr              <= '0;
`endif
        end else begin
            gnt             <= '0;
            fir_input_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt             <= CH_COUNT'(1) << win_idx;
                        fir_input_valid <= 1'b1;
                        fir_data_in     <= win_data;
                        fir_ch_sel      <= win_idx;
`ifndef FIR_ARB_FIXED_PRIO_EN
                        rr <= (win_idx == CW'(CH_COUNT - 1)) ? '0 : win_idx + CW'(1);
`endif
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (fir_output_valid) begin
                        res_data  <= fir_data_out;
                        res_ch    <= fir_ch_sel;
                        res_valid <= 1'b1;
                        cnt       <= '0;
                    end else if (cnt_at_lim) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESULT: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed bench: instance a uses the default watchdog, instance b a short one for abort cases.
module tb_fir_channel_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data;
    logic        fov = 1'b0;
    logic [39:0] fdo = '0;
    logic        res_ready = 1'b1;

    logic [15:0] ch_data [4] = '{16'hA000, 16'hB001, 16'h1234, 16'hD003};
    assign req_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    always #5 clk = ~clk;

    logic [3:0]  req_a, req_b, gnt_a, gnt_b;
    logic        fov_a, fov_b, fiv_a, fiv_b, rv_a, rv_b, busy_a, busy_b, te_a, te_b;
    logic [15:0] din_a, din_b;
    logic [1:0]  csel_a, csel_b, rch_a, rch_b;
    logic [39:0] rd_a, rd_b;

    assign req_a = sel ? 4'b0 : req;
    assign req_b = sel ? req : 4'b0;
    assign fov_a = sel ? 1'b0 : fov;
    assign fov_b = sel ? fov : 1'b0;

    fir_channel_arbiter u_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data(req_data), .gnt(gnt_a),
        .fir_input_valid(fiv_a), .fir_data_in(din_a), .fir_ch_sel(csel_a),
        .fir_output_valid(fov_a), .fir_data_out(fdo), .res_valid(rv_a), .res_ch(rch_a),
        .res_data(rd_a), .res_ready(res_ready), .busy(busy_a), .timeout_err(te_a)
    );

    fir_channel_arbiter #(.TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(req_data), .gnt(gnt_b),
        .fir_input_valid(fiv_b), .fir_data_in(din_b), .fir_ch_sel(csel_b),
        .fir_output_valid(fov_b), .fir_data_out(fdo), .res_valid(rv_b), .res_ch(rch_b),
        .res_data(rd_b), .res_ready(res_ready), .busy(busy_b), .timeout_err(te_b)
    );

    logic [3:0]  o_gnt;
    logic        o_fiv, o_rv, o_busy, o_te;
    logic [15:0] o_din;
    logic [1:0]  o_csel, o_rch;
    logic [39:0] o_rd;
    assign o_gnt  = sel ? gnt_b  : gnt_a;
    assign o_fiv  = sel ? fiv_b  : fiv_a;
    assign o_rv   = sel ? rv_b   : rv_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_te   = sel ? te_b   : te_a;
    assign o_din  = sel ? din_b  : din_a;
    assign o_csel = sel ? csel_b : csel_a;
    assign o_rch  = sel ? rch_b  : rch_a;
    assign o_rd   = sel ? rd_b   : rd_a;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Request, check the grant, play the engine with done at WAIT cycle 'lat', check the result.
    task automatic run_one(input string tag, input logic [3:0] r, input int exp_ch,
                           input int lat, input logic [39:0] val);
        logic [3:0] eg;
        eg  = 4'b0001 << exp_ch;
        req = r;
        tick();
        check({tag, "_gnt"}, 64'(o_gnt), 64'(eg));
        check({tag, "_fiv"}, 64'(o_fiv), 64'd1);
        check({tag, "_din"}, 64'(o_din), 64'(ch_data[exp_ch]));
        check({tag, "_csel"}, 64'(o_csel), 64'(exp_ch));
        req = 4'b0;
        for (int k = 0; k < lat; k++) tick();
        check({tag, "_early_rv"}, 64'(o_rv), 64'd0);
        fov = 1'b1;
        fdo = val;
        tick();
        fov = 1'b0;
        check({tag, "_rv"}, 64'(o_rv), 64'd1);
        check({tag, "_rch"}, 64'(o_rch), 64'(exp_ch));
        check({tag, "_rd"}, 64'(o_rd), 64'(val));
    endtask

    task automatic finish_res(input string tag);
        res_ready = 1'b1;
        tick();
        check({tag, "_rv_clr"}, 64'(o_rv), 64'd0);
        check({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    int rr_exp [5];
    logic bp_ok;

    initial begin
`ifdef FIR_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        tick();
        check("rst_gnt", 64'(gnt_a), 64'd0);
        check("rst_fiv", 64'(fiv_a), 64'd0);
        check("rst_rv", 64'(rv_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_te", 64'(te_b), 64'd0);
        rst = 1'b0;

        run_one("single", 4'b0100, 2, 130, 40'h00_0000_ABCD);
        finish_res("single");

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_one($sformatf("rr%0d", i), 4'b1111, rr_exp[i], 3, 40'h11_0000_0000 + 40'(i));
            finish_res($sformatf("rr%0d", i));
        end

        res_ready = 1'b0;
        run_one("bp", 4'b0001, 0, 3, 40'h55_AAAA_5555);
        req   = 4'b0010;
        bp_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!(o_rv && o_rch == 2'd0 && o_rd == 40'h55_AAAA_5555 && o_gnt == 4'b0 && o_busy))
                bp_ok = 1'b0;
        end
        check("bp_hold", 64'(bp_ok), 64'd1);
        res_ready = 1'b1;
        tick();
        check("bp_rv_clr", 64'(o_rv), 64'd0);
        check("bp_no_gnt_r1", 64'(o_gnt), 64'd0);
        run_one("bp_next", 4'b0010, 1, 3, 40'h00_0000_0777);
        finish_res("bp_next");

        req = 4'b0100;
        tick();
        req = 4'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_din", 64'(o_din), 64'd0);
        check("arst_csel", 64'(o_csel), 64'd0);
        check("arst_fiv", 64'(o_fiv), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one("arst_rr", 4'b1010, 1, 4, 40'h00_0000_0123);
        finish_res("arst_rr");

        sel = 1'b1;
        req = 4'b0001;
        tick();
        check("to_gnt", 64'(o_gnt), 64'd1);
        req = 4'b0;
        for (int k = 0; k < 8; k++) tick();
        check("to_pre_te", 64'(o_te), 64'd0);
        check("to_pre_busy", 64'(o_busy), 64'd1);
        tick();
        check("to_te", 64'(o_te), 64'd1);
        check("to_idle", 64'(o_busy), 64'd0);
        check("to_no_rv", 64'(o_rv), 64'd0);
        run_one("to_next", 4'b0100, 2, 3, 40'h00_0000_0BEE);
        finish_res("to_next");
        check("to_sticky", 64'(o_te), 64'd1);

        do_reset();
        run_one("lim", 4'b0001, 0, 8, 40'h12_3456_789A);
        finish_res("lim");
        check("lim_te", 64'(o_te), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
